// File: rtl/im_loader.sv
// Byte-stream instruction-memory loader: assembles big-endian 16-bit words from a
// valid/ready byte channel and writes them to consecutive addresses while stalling the CPU.
module im_loader #(
  parameter int MAX_WORDS = 1024,
  parameter int AW        = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          im_we,
  output logic [AW-1:0] im_waddr,
  output logic [15:0]   im_wdata,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CNT_HI = 3'd1;
  localparam logic [2:0] CNT_LO = 3'd2;
  localparam logic [2:0] DAT_HI = 3'd3;
  localparam logic [2:0] DAT_LO = 3'd4;
  localparam logic [2:0] WRITE  = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;
  localparam logic [2:0] ERR    = 3'd7;

  localparam logic [15:0] MAX_COUNT = 16'(MAX_WORDS);

  logic [2:0]  state;
  logic [2:0]  nextState;
  logic [15:0] count;
  logic [15:0] wordCnt;
  logic [7:0]  dataHi;
  logic        xfer;
  logic [15:0] fullCount;
  logic        lastWord;

  assign xfer      = in_valid && in_ready;
  assign fullCount = {count[15:8], in_data};
  assign lastWord  = (wordCnt + 16'd1) == count;

  // Next-state decode; outputs are registered from this so nothing leaks input-to-output.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:   if (start) nextState = CNT_HI;
      CNT_HI: if (xfer) nextState = CNT_LO;
      CNT_LO: begin
        if (xfer) begin
          if (fullCount == 16'd0)
            nextState = DONE;
          else if (fullCount > MAX_COUNT)
            nextState = ERR;
          else
            nextState = DAT_HI;
        end
      end
      DAT_HI: if (xfer) nextState = DAT_LO;
      DAT_LO: if (xfer) nextState = WRITE;
      WRITE:  nextState = lastWord ? DONE : DAT_HI;
      DONE:   nextState = IDLE;
      ERR:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      im_we    <= 1'b0;
      im_waddr <= '0;
      im_wdata <= '0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      count    <= '0;
      wordCnt  <= '0;
      dataHi   <= '0;
    end else begin
      state    <= nextState;
      in_ready <= (nextState == CNT_HI) || (nextState == CNT_LO) ||
                  (nextState == DAT_HI) || (nextState == DAT_LO);
      cpu_hold <= (nextState != IDLE);
      im_we    <= (nextState == WRITE);
      done     <= (nextState == DONE);

      if (state == IDLE && start)
        err <= 1'b0;
      else if (nextState == ERR)
        err <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            wordCnt  <= '0;
            im_waddr <= '0;
          end
        end
        CNT_HI: if (xfer) count[15:8] <= in_data;
        CNT_LO: if (xfer) count[7:0] <= in_data;
        DAT_HI: if (xfer) dataHi <= in_data;
        // The full word lands in im_wdata only when complete, so it is stable during WRITE.
        DAT_LO: if (xfer) im_wdata <= {dataHi, in_data};
        WRITE: begin
          wordCnt  <= wordCnt + 16'd1;
          im_waddr <= im_waddr + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: expected writes are queued as streams are driven
// and matched against im_we traffic by a negedge monitor.
module tb_im_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        im_we;
  logic [9:0]  im_waddr;
  logic [15:0] im_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  im_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;
  int writeCount = 0;
  int doneCount = 0;
  int startCyc = 0;
  logic pulseStart = 1'b0;
  logic [25:0] expQ[$];
  logic [7:0] stream[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Scoreboard side: every write must match the oldest expected {addr,data}.
  logic [25:0] expEntry;
  always @(negedge clk) begin
    if (im_we) begin
      writeCount++;
      if (expQ.size() == 0)
        checkOutput("unexpectedWrite", 32'd1, 32'd0);
      else begin
        expEntry = expQ.pop_front();
        checkOutput("writeAddr", {22'd0, im_waddr}, {22'd0, expEntry[25:16]});
        checkOutput("writeData", {16'd0, im_wdata}, {16'd0, expEntry[15:0]});
      end
    end
    if (done) begin
      doneCount++;
      checkOutput("holdWithDone", {31'd0, cpu_hold}, 32'd1);
    end
  end

  // Keeps start asserted in every busy state, including DONE, to prove it is ignored.
  always @(negedge clk) if (pulseStart) start = cpu_hold;

  task automatic startLoad();
    start = 1'b1;
    startCyc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("readyAfterStart", {31'd0, in_ready}, 32'd1);
    checkOutput("holdAfterStart", {31'd0, cpu_hold}, 32'd1);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int gap, input bit gapReady);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) checkOutput("readyTimeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (gap > 0) in_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      if (gapReady) checkOutput("readyInGap", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
    end
  endtask

  task automatic sendStream(input int gap);
    for (int i = 0; i < stream.size(); i++) begin
      applyStimulus(stream[i], (i == stream.size() - 1) ? 0 : gap, !(i >= 2 && i % 2 == 1));
    end
    in_valid = 1'b0;
  endtask

  task automatic waitDone();
    int guard = 0;
    while (!done && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) checkOutput("doneTimeout", {31'd0, done}, 32'd1);
  endtask

  task automatic pushThreeWords();
    expQ.push_back({10'd0, 16'h1234});
    expQ.push_back({10'd1, 16'hABCD});
    expQ.push_back({10'd2, 16'h8000});
    stream = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h80, 8'h00};
  endtask

  int w0;
  int d0;

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstReady", {31'd0, in_ready}, 32'd0);
    checkOutput("rstWe", {31'd0, im_we}, 32'd0);
    checkOutput("rstAddr", {22'd0, im_waddr}, 32'd0);
    checkOutput("rstData", {16'd0, im_wdata}, 32'd0);
    checkOutput("rstHold", {31'd0, cpu_hold}, 32'd0);
    checkOutput("rstDone", {31'd0, done}, 32'd0);
    checkOutput("rstErr", {31'd0, err}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] three-word load, no stalls");
    w0 = writeCount; d0 = doneCount;
    pushThreeWords();
    startLoad();
    sendStream(0);
    checkOutput("weAfterLo", {31'd0, im_we}, 32'd1);
    waitDone();
    checkOutput("loadLatency", cyc - startCyc, 32'd11);
    @(negedge clk);
    checkOutput("holdFallsWithDone", {31'd0, cpu_hold}, 32'd0);
    checkOutput("donePulseOnce", {31'd0, done}, 32'd0);
    checkOutput("writes3", writeCount - w0, 32'd3);
    checkOutput("done1", doneCount - d0, 32'd1);

    $display("[TB] three-word load with 2-cycle gaps");
    w0 = writeCount; d0 = doneCount;
    pushThreeWords();
    startLoad();
    sendStream(2);
    waitDone();
    repeat (2) @(negedge clk);
    checkOutput("gapWrites", writeCount - w0, 32'd3);
    checkOutput("gapDone", doneCount - d0, 32'd1);

    $display("[TB] zero count");
    w0 = writeCount;
    stream = '{8'h00, 8'h00};
    startLoad();
    sendStream(0);
    checkOutput("zeroDoneNow", {31'd0, done}, 32'd1);
    checkOutput("zeroLatency", cyc - startCyc, 32'd2);
    checkOutput("zeroErr", {31'd0, err}, 32'd0);
    @(negedge clk);
    checkOutput("zeroWrites", writeCount - w0, 32'd0);

    $display("[TB] oversize count 1025");
    w0 = writeCount; d0 = doneCount;
    stream = '{8'h04, 8'h01};
    startLoad();
    sendStream(0);
    checkOutput("errSet", {31'd0, err}, 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("errSticky", {31'd0, err}, 32'd1);
    checkOutput("errIdleHold", {31'd0, cpu_hold}, 32'd0);
    checkOutput("errIdleReady", {31'd0, in_ready}, 32'd0);
    checkOutput("errNoWrites", writeCount - w0, 32'd0);
    checkOutput("errNoDone", doneCount - d0, 32'd0);
    stream = '{8'h00, 8'h00};
    startLoad();
    checkOutput("errCleared", {31'd0, err}, 32'd0);
    sendStream(0);
    waitDone();
    @(negedge clk);

    $display("[TB] two-word load with start held busy");
    w0 = writeCount; d0 = doneCount;
    expQ.push_back({10'd0, 16'hCAFE});
    expQ.push_back({10'd1, 16'h0001});
    stream = '{8'h00, 8'h02, 8'hCA, 8'hFE, 8'h00, 8'h01};
    startLoad();
    pulseStart = 1'b1;
    sendStream(1);
    waitDone();
    repeat (4) @(negedge clk);
    pulseStart = 1'b0;
    start = 1'b0;
    checkOutput("busyStartWrites", writeCount - w0, 32'd2);
    checkOutput("busyStartDone", doneCount - d0, 32'd1);
    checkOutput("busyStartIdle", {31'd0, cpu_hold}, 32'd0);

    $display("[TB] reset after first word");
    expQ.push_back({10'd0, 16'h5555});
    stream = '{8'h00, 8'h03, 8'h55, 8'h55};
    startLoad();
    sendStream(0);
    checkOutput("weBeforeReset", {31'd0, im_we}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midRstReady", {31'd0, in_ready}, 32'd0);
    checkOutput("midRstWe", {31'd0, im_we}, 32'd0);
    checkOutput("midRstAddr", {22'd0, im_waddr}, 32'd0);
    checkOutput("midRstData", {16'd0, im_wdata}, 32'd0);
    checkOutput("midRstHold", {31'd0, cpu_hold}, 32'd0);
    checkOutput("midRstDone", {31'd0, done}, 32'd0);
    checkOutput("midRstErr", {31'd0, err}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    expQ.push_back({10'd0, 16'h0BAD});
    stream = '{8'h00, 8'h01, 8'h0B, 8'hAD};
    startLoad();
    sendStream(0);
    waitDone();
    @(negedge clk);

    checkOutput("scoreboardEmpty", expQ.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
